// File: rtl/axi4l_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite round-robin arbiter.
// Holds the FSM state encoding, the width defaults and the per-master slice extractor.
package axi4l_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_e;

  localparam int ADDR_WIDTH_DFLT = 32;
  localparam int DATA_WIDTH_DFLT = 32;

  // Widest supported field and the largest flattened bus (8 masters x 64 bits)
  localparam int MAX_W   = 64;
  localparam int MAX_BUS = 512;

  // Returns the w-bit field of master idx, zero-extended to MAX_W.
  // Callers truncate the result to their own field width.
  function automatic logic [MAX_W-1:0] get_slice(input logic [MAX_BUS-1:0] bus,
                                                 input int unsigned       idx,
                                                 input int unsigned       w);
    return MAX_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/axi4l_rr_picker.sv
// Combinational round-robin picker.
// Grants the first requester found scanning upward from ptr, modulo NUM_M.
module axi4l_rr_picker #(
  parameter int NUM_M = 2,
  parameter int PTR_W = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM_M-1:0] gnt,
  output logic             valid
);

  logic [NUM_M-1:0] rot_req;
  logic [NUM_M-1:0] rot_gnt;

  // Rotate so that the master at ptr lands on bit 0.
  // Isolate the lowest set bit, then rotate that bit back into place.
  assign rot_req = NUM_M'({req, req} >> ptr);
  assign rot_gnt = rot_req & (~rot_req + NUM_M'(1));
  assign gnt     = NUM_M'(({rot_gnt, rot_gnt} << ptr) >> NUM_M);
  assign valid   = |req;

endmodule

// File: rtl/axi4l_rr_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite slave port (AW/W/AR/R) between NUM_M masters.
// Only one transaction is in flight at a time; a write completes once both AW and W have handshaken.
module axi4l_rr_arbiter
  import axi4l_arb_pkg::*;
#(
  parameter int NUM_M      = 2,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [NUM_M*ADDR_WIDTH-1:0] S_AWADDR,
  input  logic [NUM_M-1:0]            S_AWVALID,
  output logic [NUM_M-1:0]            S_AWREADY,
  input  logic [NUM_M*DATA_WIDTH-1:0] S_WDATA,
  input  logic [NUM_M-1:0]            S_WVALID,
  output logic [NUM_M-1:0]            S_WREADY,
  input  logic [NUM_M*ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [NUM_M-1:0]            S_ARVALID,
  output logic [NUM_M-1:0]            S_ARREADY,
  output logic [DATA_WIDTH-1:0]       S_RDATA,
  output logic [NUM_M-1:0]            S_RVALID,
  input  logic [NUM_M-1:0]            S_RREADY,
  output logic [ADDR_WIDTH-1:0]       M_AWADDR,
  output logic                        M_AWVALID,
  input  logic                        M_AWREADY,
  output logic [DATA_WIDTH-1:0]       M_WDATA,
  output logic                        M_WVALID,
  input  logic                        M_WREADY,
  output logic [ADDR_WIDTH-1:0]       M_ARADDR,
  output logic                        M_ARVALID,
  input  logic                        M_ARREADY,
  input  logic [DATA_WIDTH-1:0]       M_RDATA,
  input  logic                        M_RVALID,
  output logic                        M_RREADY,
  output logic [NUM_M-1:0]            GNT
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  arb_state_e       state_reg,   state_next;
  logic [NUM_M-1:0] gnt_reg,     gnt_next;
  logic [IDX_W-1:0] gidx_reg,    gidx_next;
  logic [IDX_W-1:0] rr_ptr_reg,  rr_ptr_next;
  logic             aw_done_reg, aw_done_next;
  logic             w_done_reg,  w_done_next;
  logic             ar_done_reg, ar_done_next;

  logic [NUM_M-1:0] wr_req;
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] pick_gnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] ptr_inc;

  logic in_wr, in_rd_addr, in_rd_data;
  logic aw_hs, w_hs, ar_hs, r_hs;
  logic aw_now, w_now;

  assign wr_req = S_AWVALID & S_WVALID;
  assign req    = wr_req | S_ARVALID;

  axi4l_rr_picker #(
    .NUM_M (NUM_M),
    .PTR_W (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  assign ptr_inc = (gidx_reg == IDX_W'(NUM_M - 1)) ? '0 : gidx_reg + IDX_W'(1);

  assign in_wr      = (state_reg == WR);
  assign in_rd_addr = (state_reg == RD) && !ar_done_reg;
  assign in_rd_data = (state_reg == RD) && ar_done_reg;

  // Slave-side channels: each is masked once its own handshake has been recorded
  assign M_AWVALID = in_wr && !aw_done_reg && |(S_AWVALID & gnt_reg);
  assign M_WVALID  = in_wr && !w_done_reg  && |(S_WVALID  & gnt_reg);
  assign M_ARVALID = in_rd_addr && |(S_ARVALID & gnt_reg);
  assign M_RREADY  = in_rd_data && |(S_RREADY & gnt_reg);

  assign M_AWADDR = (in_wr && !aw_done_reg)
                  ? ADDR_WIDTH'(get_slice(MAX_BUS'(S_AWADDR), 32'(gidx_reg), ADDR_WIDTH)) : '0;
  assign M_WDATA  = (in_wr && !w_done_reg)
                  ? DATA_WIDTH'(get_slice(MAX_BUS'(S_WDATA), 32'(gidx_reg), DATA_WIDTH)) : '0;
  assign M_ARADDR = in_rd_addr
                  ? ADDR_WIDTH'(get_slice(MAX_BUS'(S_ARADDR), 32'(gidx_reg), ADDR_WIDTH)) : '0;
  assign S_RDATA  = in_rd_data ? M_RDATA : '0;

  assign aw_hs = M_AWVALID && M_AWREADY;
  assign w_hs  = M_WVALID  && M_WREADY;
  assign ar_hs = M_ARVALID && M_ARREADY;
  assign r_hs  = in_rd_data && M_RVALID && M_RREADY;

  // Ready/valid returned only to the granted master
  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
    assign S_AWREADY[gi] = in_wr && gnt_reg[gi] && !aw_done_reg && M_AWREADY;
    assign S_WREADY[gi]  = in_wr && gnt_reg[gi] && !w_done_reg  && M_WREADY;
    assign S_ARREADY[gi] = in_rd_addr && gnt_reg[gi] && M_ARREADY;
    assign S_RVALID[gi]  = in_rd_data && gnt_reg[gi] && M_RVALID;
  end

  assign GNT = gnt_reg;

  assign aw_now = aw_done_reg || aw_hs;
  assign w_now  = w_done_reg  || w_hs;

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gidx_next    = gidx_reg;
    rr_ptr_next  = rr_ptr_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    ar_done_next = ar_done_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next     = pick_gnt;
          gidx_next    = pick_idx;
          state_next   = (|(pick_gnt & wr_req)) ? WR : RD;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          ar_done_next = 1'b0;
        end
      end
      WR: begin
        aw_done_next = aw_now;
        w_done_next  = w_now;
        if (aw_now && w_now) begin
          state_next   = IDLE;
          gnt_next     = '0;
          rr_ptr_next  = ptr_inc;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      RD: begin
        if (!ar_done_reg) begin
          ar_done_next = ar_hs;
        end else if (r_hs) begin
          state_next   = IDLE;
          gnt_next     = '0;
          rr_ptr_next  = ptr_inc;
          ar_done_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gidx_reg    <= '0;
      rr_ptr_reg  <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      ar_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gidx_reg    <= gidx_next;
      rr_ptr_reg  <= rr_ptr_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      ar_done_reg <= ar_done_next;
    end
  end

endmodule

// File: tb/tb_axi4l_rr_arbiter.sv
// Directed self-checking bench for axi4l_rr_arbiter with two masters.
// Inputs change 2 time units after the rising edge; checks follow 1 unit later.
module tb_axi4l_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [NM*AW-1:0]  S_AWADDR, S_ARADDR;
  logic [NM*DW-1:0]  S_WDATA;
  logic [NM-1:0]     S_AWVALID, S_WVALID, S_ARVALID, S_RREADY;
  logic [NM-1:0]     S_AWREADY, S_WREADY, S_ARREADY, S_RVALID;
  logic [DW-1:0]     S_RDATA;
  logic [AW-1:0]     M_AWADDR, M_ARADDR;
  logic [DW-1:0]     M_WDATA, M_RDATA;
  logic              M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic              M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [NM-1:0]     GNT;

  int tests = 0;
  int fails = 0;

  axi4l_rr_arbiter #(.NUM_M(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .GNT(GNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  initial begin
    ARESET = 1'b1;
    S_AWADDR = '0; S_ARADDR = '0; S_WDATA = '0;
    S_AWVALID = '0; S_WVALID = '0; S_ARVALID = '0; S_RREADY = '0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
    M_RVALID = 1'b0; M_RDATA = '0;
    #3;
    chk("rst_gnt",      GNT, 0);
    chk("rst_awvalid",  M_AWVALID, 0);
    chk("rst_rready",   M_RREADY, 0);
    chk("rst_s_awready", S_AWREADY, 0);
    chk("rst_awaddr",   M_AWADDR, 0);
    cyc(); cyc();
    ARESET = 1'b0;

    // Single write from M0
    S_AWADDR[AW-1:0] = 32'h10; S_WDATA[DW-1:0] = 32'hA5A5;
    S_AWVALID = 2'b01; S_WVALID = 2'b01; M_AWREADY = 1'b1; M_WREADY = 1'b1;
    #1 chk("wr1_gnt_latency", GNT, 0);
    cyc();
    chk("wr1_gnt",       GNT, 2'b01);
    chk("wr1_awvalid",   M_AWVALID, 1);
    chk("wr1_awaddr",    M_AWADDR, 32'h10);
    chk("wr1_wdata",     M_WDATA, 32'hA5A5);
    chk("wr1_s_awready", S_AWREADY, 2'b01);
    chk("wr1_s_wready",  S_WREADY, 2'b01);
    cyc();
    S_AWVALID = '0; S_WVALID = '0;
    #1;
    chk("wr1_idle_gnt",  GNT, 0);
    chk("wr1_awready_once", S_AWREADY, 0);
    chk("wr1_wready_once",  S_WREADY, 0);

    // Slave read data arriving while idle must not reach any master
    M_RVALID = 1'b1;
    #1;
    chk("idle_rvalid_ignored", S_RVALID, 0);
    chk("idle_rready", M_RREADY, 0);
    M_RVALID = 1'b0;

    // Read from M1 with a 3-cycle slave delay
    cyc();
    S_ARADDR[2*AW-1:AW] = 32'h20; S_ARVALID = 2'b10; S_RREADY = 2'b11; M_ARREADY = 1'b1;
    cyc();
    chk("rd1_gnt",       GNT, 2'b10);
    chk("rd1_arvalid",   M_ARVALID, 1);
    chk("rd1_araddr",    M_ARADDR, 32'h20);
    chk("rd1_s_arready", S_ARREADY, 2'b10);
    cyc();
    S_ARVALID = '0;
    #1;
    chk("rd1_rvalid_wait", S_RVALID, 0);
    chk("rd1_m_rready",  M_RREADY, 1);
    chk("rd1_arvalid_off", M_ARVALID, 0);
    cyc(); cyc();
    M_RVALID = 1'b1; M_RDATA = 32'hDEAD;
    #1;
    chk("rd1_s_rvalid",  S_RVALID, 2'b10);
    chk("rd1_s_rdata",   S_RDATA, 32'hDEAD);
    cyc();
    M_RVALID = 1'b0;
    #1;
    chk("rd1_rvalid_one", S_RVALID, 0);
    chk("rd1_idle_gnt",  GNT, 0);

    // Split write from M0 while M1 holds ARVALID (ptr now at 0)
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
    S_AWADDR[AW-1:0] = 32'h14; S_WDATA[DW-1:0] = 32'h1234;
    S_AWVALID = 2'b01; S_WVALID = 2'b01;
    S_ARADDR[2*AW-1:AW] = 32'h24; S_ARVALID = 2'b10;
    cyc();
    chk("sw_gnt",        GNT, 2'b01);
    chk("sw_awvalid",    M_AWVALID, 1);
    chk("sw_arvalid_stall", M_ARVALID, 0);
    cyc();
    M_AWREADY = 1'b1;
    #1;
    chk("sw_s_awready",  S_AWREADY, 2'b01);
    chk("sw_s_wready_lo", S_WREADY, 0);
    cyc();
    S_AWVALID = '0;
    #1;
    chk("sw_awvalid_masked", M_AWVALID, 0);
    chk("sw_awready_masked", S_AWREADY, 0);
    chk("sw_wvalid_held", M_WVALID, 1);
    cyc(); cyc();
    chk("sw_gnt_held",   GNT, 2'b01);
    chk("sw_s_arready_stall", S_ARREADY, 0);
    M_WREADY = 1'b1;
    #1;
    chk("sw_s_wready",   S_WREADY, 2'b01);
    cyc();
    S_WVALID = '0;
    #1;
    chk("sw_idle_gnt",   GNT, 0);
    M_ARREADY = 1'b1;
    cyc();
    chk("sw_rd_gnt",     GNT, 2'b10);
    chk("sw_rd_araddr",  M_ARADDR, 32'h24);
    cyc();
    S_ARVALID = '0; M_RVALID = 1'b1; M_RDATA = 32'hBEEF;
    #1;
    chk("sw_rd_s_rvalid", S_RVALID, 2'b10);
    chk("sw_rd_s_rdata", S_RDATA, 32'hBEEF);
    cyc();
    M_RVALID = 1'b0;

    // Fairness: both masters write continuously, ptr back at 0
    S_AWADDR = {32'h200, 32'h100}; S_WDATA = {32'h2222, 32'h1111};
    S_AWVALID = 2'b11; S_WVALID = 2'b11; M_AWREADY = 1'b1; M_WREADY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("fair%0d_gnt", k),    GNT, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fair%0d_awaddr", k), M_AWADDR, (k % 2 == 0) ? 32'h100 : 32'h200);
      cyc();
      chk($sformatf("fair%0d_idle", k),   GNT, 0);
    end
    S_AWVALID = '0; S_WVALID = '0;

    // Same master with write and read pending: write first
    S_AWADDR[AW-1:0] = 32'h40; S_ARADDR[AW-1:0] = 32'h44;
    S_AWVALID = 2'b01; S_WVALID = 2'b01; S_ARVALID = 2'b01;
    cyc();
    chk("wr_rd_gnt_wr",  GNT, 2'b01);
    chk("wr_rd_awvalid", M_AWVALID, 1);
    chk("wr_rd_arvalid_lo", M_ARVALID, 0);
    cyc();
    S_AWVALID = '0; S_WVALID = '0;
    #1 chk("wr_rd_idle", GNT, 0);
    cyc();
    chk("wr_rd_gnt_rd",  GNT, 2'b01);
    chk("wr_rd_arvalid", M_ARVALID, 1);
    chk("wr_rd_araddr",  M_ARADDR, 32'h44);
    chk("wr_rd_awvalid_lo", M_AWVALID, 0);
    cyc();
    S_ARVALID = '0;
    #1;
    chk("pre_rst_rready", M_RREADY, 1);

    // Asynchronous reset during the read data phase
    M_RVALID = 1'b1;
    #1 chk("pre_rst_s_rvalid", S_RVALID, 2'b01);
    #1 ARESET = 1'b1;
    #1;
    chk("rst_rd_gnt",    GNT, 0);
    chk("rst_rd_rready", M_RREADY, 0);
    chk("rst_rd_s_rvalid", S_RVALID, 0);
    M_RVALID = 1'b0;
    cyc(); cyc();
    ARESET = 1'b0;
    S_AWADDR[2*AW-1:AW] = 32'h30; S_AWVALID = 2'b10; S_WVALID = 2'b10;
    #1 chk("post_rst_gnt_wait", GNT, 0);
    cyc();
    chk("post_rst_gnt",  GNT, 2'b10);
    chk("post_rst_awaddr", M_AWADDR, 32'h30);
    cyc();
    S_AWVALID = '0; S_WVALID = '0;
    #1 chk("post_rst_idle", GNT, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
